wb_port_arbiter: RTL

//  Shares the single register-file write port between two result sources.
//  - In-order pipeline write-back: selects read_data when MemtoReg=1, else ALU_result.
//  - Long-latency execution unit (mul/div): valid/ready handshake.

---
 rtl/wb_port_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Shares the single register-file write port between the in-order pipeline
// write-back stage and a long-latency execution unit (mul/div).
//
// Pipeline results win the port by fixed priority. Unit results are buffered
// in a small FIFO and drained on cycles where the pipeline does not write.
// Every write reaches the regfile port one cycle after its grant.
//
// Optional feature (compile-time macro WB_STARVE_GUARD_EN):
//   When defined, a starve counter watches the FIFO head. If the head is
//   denied the port for MAX_WAIT-1 consecutive cycles, pipe_stall is raised
//   for one cycle and the head is written in that cycle. When undefined,
//   pipe_stall is tied low and a busy pipeline may starve the FIFO.
//
// Parameters:
//   DEPTH     unit-result FIFO entries (power of 2, >= 2)
//   MAX_WAIT  head wait limit in cycles for the starve guard (>= 2)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pipe_valid          pipeline WB slot carries a register write
//   pipe_rd             pipeline destination register
//   pipe_MemtoReg       1: write pipe_read_data, 0: write pipe_ALU_result
//   pipe_read_data      load data
//   pipe_ALU_result     ALU result
//   ext_valid/ext_ready unit result handshake (ready from registered count)
//   ext_rd, ext_data    unit destination register and result
//   rf_we/waddr/wdata   registered regfile write port
//   pipe_stall          registered; pipeline must hold its WB inputs
//   fifo_count          current FIFO occupancy
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pipe_valid,
  input  logic [4:0]               pipe_rd,
  input  logic                     pipe_MemtoReg,
  input  logic [31:0]              pipe_read_data,
  input  logic [31:0]              pipe_ALU_result,
  input  logic                     ext_valid,
  output logic                     ext_ready,
  input  logic [4:0]               ext_rd,
  input  logic [31:0]              ext_data,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  output logic                     pipe_stall,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    mem_rd   [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          push;
  logic          pop;
  logic          stall_now;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  assign ext_ready  = (count != CW'(DEPTH));
  assign push       = ext_valid && ext_ready;
  // A stall cycle hands the port to the FIFO regardless of pipe_valid.
  assign pop        = (count != '0) && (stall_now || !pipe_valid);
  assign head_rd    = mem_rd[rd_ptr];
  assign head_data  = mem_data[rd_ptr];
  assign fifo_count = count;
  assign pipe_stall = stall_now;

  // FIFO storage is not reset; entries are only read while count says valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr]   <= ext_rd;
      mem_data[wr_ptr] <= ext_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // rd==0 still consumes the grant and updates address/data, but never writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (pop) begin
      rf_we    <= (head_rd != 5'd0);
      rf_waddr <= head_rd;
      rf_wdata <= head_data;
    end else if (pipe_valid && !stall_now) begin
      rf_we    <= (pipe_rd != 5'd0);
      rf_waddr <= pipe_rd;
      rf_wdata <= pipe_MemtoReg ? pipe_read_data : pipe_ALU_result;
    end else begin
      rf_we    <= 1'b0;
    end
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(MAX_WAIT) + 1;

  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_next;
  logic          stall_q;

  // Counts consecutive cycles the head is denied; a pop or empty FIFO clears it.
  always_comb begin
    starve_next = starve_cnt + SW'(1);
    if (pop || (count == '0)) starve_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      stall_q    <= (starve_next == SW'(MAX_WAIT - 1));
    end
  end

  assign stall_now = stall_q;
`else
  assign stall_now = 1'b0;
`endif

endmodule
